// File: rtl/instr_pkg.sv
// Shared constants and FSM state type for the instructions overlay.
// Image geometry is in ROM pixels; SCALE maps each to a SCALE x SCALE screen block.
package instr_pkg;

    localparam int IMG_W       = 150;
    localparam int IMG_H       = 100;
    localparam int SCALE       = 2;
    localparam int PROMPT_ROW0 = 88;
    localparam int ADDR_W      = 15;

    typedef enum logic {
        HIDDEN  = 1'b0,
        VISIBLE = 1'b1
    } state_t;

endpackage

// File: rtl/instructions_overlay_rom.sv
// instructionsROM: 150x100 1-bit splash image, registered read (1 Clk latency).
// Ports: Clk, read_address[14:0] in; data_Out out (valid one Clk after address).
module instructionsROM (
    input  logic        Clk,
    input  logic [14:0] read_address,
    output logic        data_Out
);

    // Procedural stand-in for the bitmap contents: a parity pattern over a
    // few address bits, giving a mix of set and clear pixels.
    always_ff @(posedge Clk) begin
        data_Out <= ^(read_address & 15'h0209);
    end

endmodule

// File: rtl/instructions_overlay.sv
// Centred 2x-scaled instructions splash overlay with blinking key prompt.
// Ports: Clk, Reset (sync, high), frame_start, DrawX/DrawY[9:0], show,
//        key_pressed in; pixel_on, pixel_rgb[23:0], done out. 3 Clk latency.
module instructions_overlay
    import instr_pkg::*;
#(
    parameter int          X0        = 170,
    parameter int          Y0        = 140,
    parameter logic [23:0] FG_RGB    = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB    = 24'h101030,
    parameter int          BLINK_BIT = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        show,
    input  logic        key_pressed,
    output logic        pixel_on,
    output logic [23:0] pixel_rgb,
    output logic        done
);

    localparam int SH = $clog2(SCALE);
    localparam logic [9:0] XL = 10'(X0);
    localparam logic [9:0] XH = 10'(X0 + IMG_W * SCALE);
    localparam logic [9:0] YL = 10'(Y0);
    localparam logic [9:0] YH = 10'(Y0 + IMG_H * SCALE);

    // ---------------- control FSM ----------------
    state_t     state, state_n;
    logic [5:0] cnt, cnt_n;
    logic       dp, dp_n;
    logic       key_prev;
    logic       key_rise;
    logic       done_n;

    assign key_rise = key_pressed & ~key_prev;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dp_n    = dp;
        done_n  = 1'b0;
        unique case (state)
            HIDDEN: begin
                if (frame_start && show) begin
                    state_n = VISIBLE;
                    cnt_n   = '0;
                    dp_n    = 1'b0;
                end
            end
            VISIBLE: begin
                if (key_rise)
                    dp_n = 1'b1;
                if (frame_start) begin
                    cnt_n = cnt + 6'd1;
                    // Exit decision uses the pending flag as it stood
                    // before this cycle's key edge.
                    if (dp || !show) begin
                        state_n = HIDDEN;
                        done_n  = dp;
                        dp_n    = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= HIDDEN;
            cnt      <= '0;
            dp       <= 1'b0;
            key_prev <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dp       <= dp_n;
            key_prev <= key_pressed;
            done     <= done_n;
        end
    end

    // ---------------- stage 1: window + address ----------------
    logic [9:0]        dx, dy;
    logic [7:0]        col;
    logic [6:0]        row;
    logic              in_win, in_prm;
    logic [ADDR_W-1:0] addr;

    always_comb begin
        dx     = DrawX - XL;
        dy     = DrawY - YL;
        col    = 8'(dx >> SH);
        row    = 7'(dy >> SH);
        in_win = (DrawX >= XL) && (DrawX < XH) &&
                 (DrawY >= YL) && (DrawY < YH);
        in_prm = in_win && (row >= 7'(PROMPT_ROW0));
        addr   = '0;
        if (in_win)
            // row*150 as shift-add: 128 + 16 + 4 + 2
            addr = (15'(row) << 7) + (15'(row) << 4)
                 + (15'(row) << 2) + (15'(row) << 1)
                 + 15'(col);
    end

    logic [ADDR_W-1:0] addr_s1;
    logic              win_s1, prm_s1, en_s1;
    logic              win_s2, prm_s2, en_s2;
    logic              rom_bit;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_s1 <= '0;
            win_s1  <= 1'b0;
            prm_s1  <= 1'b0;
            en_s1   <= 1'b0;
            win_s2  <= 1'b0;
            prm_s2  <= 1'b0;
            en_s2   <= 1'b0;
        end else begin
            addr_s1 <= addr;
            win_s1  <= in_win;
            prm_s1  <= in_prm;
            en_s1   <= (state == VISIBLE);
            win_s2  <= win_s1;
            prm_s2  <= prm_s1;
            en_s2   <= en_s1;
        end
    end

    // ---------------- stage 2: ROM read ----------------
    // ROM data register is not reset; the zeroed flags mask it.
    instructionsROM u_rom (
        .Clk          (Clk),
        .read_address (addr_s1),
        .data_Out     (rom_bit)
    );

    // ---------------- stage 3: output ----------------
    logic prompt_ok, on_n;

    assign prompt_ok = ~prm_s2 | ~cnt[BLINK_BIT];
    assign on_n      = en_s2 & win_s2 & prompt_ok;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pixel_on  <= 1'b0;
            pixel_rgb <= '0;
        end else begin
            pixel_on  <= on_n;
            pixel_rgb <= on_n ? (rom_bit ? FG_RGB : BG_RGB) : 24'h0;
        end
    end

endmodule

// File: tb/tb_instructions_overlay.sv
// Self-checking bench for instructions_overlay against a behavioural model.
// Model tracks visibility, frames since entry and pending dismissal.
module tb_instructions_overlay;

    logic        Clk = 1'b0;
    logic        Reset, frame_start, show, key_pressed;
    logic [9:0]  DrawX, DrawY;
    logic        pixel_on, done;
    logic [23:0] pixel_rgb;

    int total = 0;
    int bad   = 0;

    bit m_vis, m_pend, m_kprev;
    int m_frames;

    always #5 Clk = ~Clk;

    instructions_overlay dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .show        (show),
        .key_pressed (key_pressed),
        .pixel_on    (pixel_on),
        .pixel_rgb   (pixel_rgb),
        .done        (done)
    );

    function automatic bit rom_bit(int a);
        return ($countones(a & 32'h209) % 2) == 1;
    endfunction

    function automatic bit ex_on(int x, int y);
        int row;
        if (!m_vis) return 1'b0;
        if (x < 170 || x >= 470 || y < 140 || y >= 340) return 1'b0;
        row = (y - 140) / 2;
        if (row >= 88 && (m_frames % 64) >= 32) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [23:0] ex_rgb(int x, int y);
        int a;
        if (!ex_on(x, y)) return 24'h0;
        a = ((y - 140) / 2) * 150 + (x - 170) / 2;
        return rom_bit(a) ? 24'hFFFFFF : 24'h101030;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic probe(input int x, input int y,
                         output logic on, output logic [23:0] rgb);
        DrawX = 10'(x);
        DrawY = 10'(y);
        repeat (3) step();
        on  = pixel_on;
        rgb = pixel_rgb;
    endtask

    task automatic set_key(input bit v);
        key_pressed = v;
        if (v && !m_kprev && m_vis) m_pend = 1'b1;
        m_kprev = v;
        step();
    endtask

    task automatic pulse_frame(output logic d1, output logic d2,
                               output bit exp_d);
        exp_d = m_vis && m_pend;
        if (m_vis) begin
            if (m_pend || !show) begin
                m_vis  = 1'b0;
                m_pend = 1'b0;
            end else begin
                m_frames++;
            end
        end else if (show) begin
            m_vis    = 1'b1;
            m_frames = 0;
            m_pend   = 1'b0;
        end
        DrawX = 10'd0;
        DrawY = 10'd0;
        frame_start = 1'b1;
        step();
        d1 = done;
        frame_start = 1'b0;
        step();
        d2 = done;
    endtask

    task automatic test_reset();
        logic d1, d2;
        bit   e;
        Reset = 1'b1;
        show = 1'b0;
        frame_start = 1'b0;
        key_pressed = 1'b0;
        DrawX = 10'd300;
        DrawY = 10'd200;
        m_vis = 0; m_pend = 0; m_kprev = 0; m_frames = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({pixel_on, pixel_rgb, done} !== 26'b0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d on=%b rgb=%h done=%b want 0",
                         i, pixel_on, pixel_rgb, done);
            end
        end
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            DrawX = 10'($urandom_range(150, 490));
            DrawY = 10'($urandom_range(120, 360));
            step();
            total++;
            if ({pixel_on, pixel_rgb, done} !== 26'b0) begin
                bad++;
                $display("FAIL idle_sweep cyc=%0d on=%b rgb=%h done=%b want 0",
                         i, pixel_on, pixel_rgb, done);
            end
        end
        pulse_frame(d1, d2, e);
        total++;
        if (d1 !== 1'b0 || pixel_on !== 1'b0) begin
            bad++;
            $display("FAIL hidden_frame done=%b on=%b want 0 0", d1, pixel_on);
        end
    endtask

    task automatic test_entry();
        logic        d1, d2, on;
        logic [23:0] rgb;
        bit          e;
        int xs[12] = '{170, 171, 172, 469, 169, 470,
                       300, 300, 300, 170, 171, 468};
        int ys[12] = '{140, 140, 140, 339, 200, 200,
                       139, 339, 340, 315, 316, 338};
        show = 1'b1;
        pulse_frame(d1, d2, e);
        total++;
        if (d1 !== e) begin
            bad++;
            $display("FAIL entry_done got=%b want=%b", d1, e);
        end
        for (int i = 0; i < 12; i++) begin
            probe(xs[i], ys[i], on, rgb);
            total++;
            if (on !== ex_on(xs[i], ys[i]) ||
                rgb !== ex_rgb(xs[i], ys[i])) begin
                bad++;
                $display("FAIL entry_px (%0d,%0d) got %b/%h want %b/%h",
                         xs[i], ys[i], on, rgb,
                         ex_on(xs[i], ys[i]), ex_rgb(xs[i], ys[i]));
            end
        end
        probe(172, 140, on, rgb);
        total++;
        if (on !== 1'b1 || rgb !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL addr1_fg got %b/%h want 1/ffffff", on, rgb);
        end
        probe(171, 141, on, rgb);
        total++;
        if (on !== 1'b1 || rgb !== 24'h101030) begin
            bad++;
            $display("FAIL addr0_bg got %b/%h want 1/101030", on, rgb);
        end
    endtask

    task automatic test_stream();
        logic        qon[$];
        logic [23:0] qrgb[$];
        logic        eo;
        logic [23:0] er;
        int x, y;
        for (int k = 0; k < 203; k++) begin
            if (k >= 3) begin
                eo = qon.pop_front();
                er = qrgb.pop_front();
                total++;
                if (pixel_on !== eo || pixel_rgb !== er) begin
                    bad++;
                    $display("FAIL stream k=%0d got %b/%h want %b/%h",
                             k - 3, pixel_on, pixel_rgb, eo, er);
                end
            end
            if (k < 200) begin
                x = $urandom_range(160, 480);
                y = $urandom_range(130, 350);
                qon.push_back(ex_on(x, y));
                qrgb.push_back(ex_rgb(x, y));
                DrawX = 10'(x);
                DrawY = 10'(y);
            end
            step();
        end
    endtask

    task automatic test_dismiss();
        logic        d1, d2, on;
        logic [23:0] rgb;
        bit          e;
        set_key(1'b1);
        probe(200, 150, on, rgb);
        total++;
        if (on !== 1'b1 || rgb !== ex_rgb(200, 150)) begin
            bad++;
            $display("FAIL dismiss_still_drawn got %b/%h want 1/%h",
                     on, rgb, ex_rgb(200, 150));
        end
        pulse_frame(d1, d2, e);
        total++;
        if (d1 !== 1'b1 || e !== 1'b1 || d2 !== 1'b0) begin
            bad++;
            $display("FAIL dismiss_done got %b,%b want 1,0", d1, d2);
        end
        probe(200, 150, on, rgb);
        total++;
        if (on !== 1'b0 || rgb !== 24'h0) begin
            bad++;
            $display("FAIL dismiss_hidden got %b/%h want 0/0", on, rgb);
        end
        set_key(1'b0);
    endtask

    task automatic test_blink();
        logic        d1, d2, on;
        logic [23:0] rgb;
        bit          e;
        show = 1'b1;
        pulse_frame(d1, d2, e);
        for (int f = 0; f <= 64; f++) begin
            probe(300, 316, on, rgb);
            total++;
            if (on !== ex_on(300, 316) || rgb !== ex_rgb(300, 316)) begin
                bad++;
                $display("FAIL blink_row88 frame=%0d got %b/%h want %b/%h",
                         f, on, rgb, ex_on(300, 316), ex_rgb(300, 316));
            end
            probe(300, 314, on, rgb);
            total++;
            if (on !== 1'b1 || rgb !== ex_rgb(300, 314)) begin
                bad++;
                $display("FAIL blink_row87 frame=%0d got %b/%h want 1/%h",
                         f, on, rgb, ex_rgb(300, 314));
            end
            pulse_frame(d1, d2, e);
            total++;
            if (d1 !== 1'b0) begin
                bad++;
                $display("FAIL blink_done frame=%0d got %b want 0", f, d1);
            end
        end
        show = 1'b0;
        pulse_frame(d1, d2, e);
        probe(300, 200, on, rgb);
        total++;
        if (d1 !== 1'b0 || on !== 1'b0) begin
            bad++;
            $display("FAIL show_low_exit done=%b on=%b want 0 0", d1, on);
        end
    endtask

    task automatic test_key_held();
        logic        d1, d2, on;
        logic [23:0] rgb;
        bit          e;
        set_key(1'b1);
        show = 1'b1;
        pulse_frame(d1, d2, e);
        for (int i = 0; i < 3; i++) begin
            pulse_frame(d1, d2, e);
            probe(250, 180, on, rgb);
            total++;
            if (d1 !== 1'b0 || on !== 1'b1) begin
                bad++;
                $display("FAIL key_held fr=%0d done=%b on=%b want 0 1",
                         i, d1, on);
            end
        end
        set_key(1'b0);
        set_key(1'b1);
        pulse_frame(d1, d2, e);
        total++;
        if (d1 !== 1'b1 || e !== 1'b1) begin
            bad++;
            $display("FAIL key_repress done=%b want 1", d1);
        end
        set_key(1'b0);
    endtask

    task automatic test_same_cycle();
        logic        d1, d2, on;
        logic [23:0] rgb;
        bit          e;
        show = 1'b1;
        pulse_frame(d1, d2, e);
        key_pressed = 1'b1;
        frame_start = 1'b1;
        step();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL same_cycle_done got %b want 0", done);
        end
        frame_start = 1'b0;
        step();
        m_kprev = 1'b1;
        m_pend  = 1'b1;
        m_frames++;
        probe(400, 250, on, rgb);
        total++;
        if (on !== 1'b1) begin
            bad++;
            $display("FAIL same_cycle_vis got %b want 1", on);
        end
        pulse_frame(d1, d2, e);
        total++;
        if (d1 !== 1'b1) begin
            bad++;
            $display("FAIL same_cycle_next got %b want 1", d1);
        end
        set_key(1'b0);
    endtask

    task automatic test_reset_mid();
        logic        d1, d2, on;
        logic [23:0] rgb;
        bit          e;
        show = 1'b1;
        pulse_frame(d1, d2, e);
        set_key(1'b1);
        probe(250, 200, on, rgb);
        total++;
        if (on !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_on got %b want 1", on);
        end
        Reset = 1'b1;
        step();
        total++;
        if (pixel_on !== 1'b0 || pixel_rgb !== 24'h0) begin
            bad++;
            $display("FAIL mid_reset got %b/%h want 0/0",
                     pixel_on, pixel_rgb);
        end
        Reset  = 1'b0;
        m_vis  = 1'b0;
        m_pend = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (pixel_on !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL post_reset cyc=%0d on=%b done=%b want 0 0",
                         i, pixel_on, done);
            end
        end
        m_kprev = key_pressed;
        pulse_frame(d1, d2, e);
        probe(250, 200, on, rgb);
        total++;
        if (d1 !== 1'b0 || d2 !== 1'b0 || on !== 1'b1) begin
            bad++;
            $display("FAIL reentry done=%b,%b on=%b want 0,0 1",
                     d1, d2, on);
        end
        set_key(1'b0);
        show = 1'b0;
        pulse_frame(d1, d2, e);
    endtask

    initial begin
        test_reset();
        test_entry();
        test_stream();
        test_dismiss();
        test_blink();
        test_key_held();
        test_same_cycle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/instructions_overlay.md
# instructions_overlay

Renders the instructions splash screen as a centred, 2x-scaled overlay on the VGA raster. It sits between the VGA controller (DrawX/DrawY) and the colour mapper. It generates addresses for the 150x100, 1-bit instructions ROM and pipelines the window/prompt flags to match the ROM's read latency. A small FSM shows and dismisses the overlay on frame boundaries, and blinks the "press key" prompt.

## Interface
- X0, 170: screen x of the overlay's left edge.
- Y0, 140: screen y of the overlay's top edge.
- FG_RGB, 24'hFFFFFF: colour for ROM bit 1.
- BG_RGB, 24'h101030: colour for ROM bit 0 inside the window.
- BLINK_BIT, 5: frame-counter bit that gates the prompt.
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- DrawX  in  10  current pixel x.
- DrawY  in  10  current pixel y.
- show  in  1  level from the game FSM requesting the overlay.
- key_pressed  in  1  level, any start key held.
- pixel_on  out  1  overlay owns this pixel.
- pixel_rgb  out  24  overlay colour; 0 when pixel_on = 0.
- done  out  1  one-cycle pulse when dismissed by key.

## Operation
- FSM states are HIDDEN and VISIBLE. Reset state is HIDDEN.
- HIDDEN -> VISIBLE: on frame_start with show = 1.
  - Entry clears the frame counter and dismiss_pending.
- While VISIBLE:
  - A rising edge of key_pressed sets dismiss_pending.
  - The edge detector's previous-key register runs in both states, so a key already held on entry does not count.
- VISIBLE -> HIDDEN: on frame_start with dismiss_pending = 1 or show = 0.
  - done pulses for 1 cycle only when dismiss_pending = 1.
- If a key edge and frame_start arrive in the same cycle, the transition tests the old dismiss_pending value. Exit therefore happens at the following frame_start.
- Frame counter: 6 bits, +1 on each frame_start while VISIBLE, wraps 63 -> 0.
- Window: X0 <= DrawX < X0+300 and Y0 <= DrawY < Y0+200.
- Image coordinates: col = (DrawX-X0)>>1 and row = (DrawY-Y0)>>1.
- ROM address = row*150 + col, 15 bits, range 0..14999.
  - Computed as shift-add: (row<<7)+(row<<4)+(row<<2)+(row<<1)+col.
- Prompt region: image rows 88..99. It is drawn only when counter[BLINK_BIT] = 0; otherwise the pixel is treated as outside the window.
- Output:
  - pixel_on = VISIBLE & in_window & prompt_ok.
  - pixel_rgb = ROM bit ? FG_RGB : BG_RGB when pixel_on = 1, else 0.

## Timing
- Stage 1 registers the ROM address, in_window, in_prompt and VISIBLE-gated enable from DrawX/DrawY.
- Stage 2: the ROM returns its data bit (ROM is registered, 1-cycle latency). The stage-1 flags are delayed one register to stay aligned.
- Stage 3 registers pixel_on and pixel_rgb.
- Total latency from DrawX/DrawY to outputs is exactly 3 Clk. The colour mapper compensates.
- A state change takes effect on pixels whose stage 1 follows the transition cycle. No frame-start clipping is needed, because transitions occur during blanking.
- On Reset, from the next edge: state = HIDDEN, counter = 0, dismiss_pending = 0, all pipeline flags = 0, pixel_on = 0, pixel_rgb = 0, done = 0.
  - The ROM data register is not reset; it is masked by the zeroed flags.
- Reset mid-frame blanks the output on the next cycle, and done is never emitted.

## Structure
- Package instr_pkg holds IMG_W = 150, IMG_H = 100, SCALE = 2, PROMPT_ROW0 = 88, and the state enum (HIDDEN, VISIBLE).
- One sub-module: instructionsROM (existing 15-bit address, 1-bit registered data), instantiated once.
- Everything else lives in this block: address arithmetic, flag pipeline, FSM, edge detect, frame counter.

## Test plan
- Reset held 2 cycles, show = 0, sweep DrawX/DrawY -> pixel_on = 0, pixel_rgb = 0, done = 0 throughout.
- show = 1 and frame_start, then drive DrawY = 140 with DrawX = 170, 171, 172 -> 3 cycles later pixel_on = 1 and ROM addresses 0, 0, 1 are observed. DrawX = 469, DrawY = 339 -> address 14999. DrawX = 169 or 470 -> pixel_on = 0.
- VISIBLE, key rising edge mid-frame -> still drawn. At the next frame_start, done = 1 for 1 cycle, state = HIDDEN, pixel_on = 0 afterwards.
- Blink: DrawY = 316 (row 88) -> drawn for frames 0-31 after entry, pixel_on = 0 for frames 32-63, drawn again at frame 64. DrawY = 314 (row 87) is always drawn.
- key_pressed held high across entry to VISIBLE -> no dismissal over 3 frames. Release and re-press -> done at the next frame_start.
- Reset asserted mid-frame while VISIBLE with dismiss_pending = 1 -> the next cycle shows pixel_on = 0, done never pulses, and the block waits in HIDDEN for show and frame_start.
